// File: rtl/i2s_tx.sv
// i2s_tx: 24-bit mono I2S serializer toward the DAC.
// Generates BCLK/LRCLK/SDATA from the system clock; one sample per frame on both slots.
module i2s_tx #(
  parameter int SAMPLE_WIDTH  = 24,
  parameter int SLOT_BITS     = 25,
  parameter int BCLK_HALF_DIV = 10
) (
  input  logic                           system_clock,
  input  logic                           rst,
  input  logic signed [SAMPLE_WIDTH-1:0] sample_in,
  input  logic                           sample_valid,
  output logic                           sample_ready,
  input  logic                           mute,
  output logic                           i2s_bclk,
  output logic                           i2s_lrclk,
  output logic                           i2s_sdata,
  output logic                           underrun
);

  localparam int DW = (BCLK_HALF_DIV > 1) ? $clog2(BCLK_HALF_DIV) : 1;
  localparam int PW = $clog2(2 * SLOT_BITS);

  localparam logic [DW-1:0] DIV_LAST = DW'(BCLK_HALF_DIV - 1);
  localparam logic [PW-1:0] POS_LAST = PW'(2 * SLOT_BITS - 1);
  localparam logic [PW-1:0] POS_SLOT = PW'(SLOT_BITS);

  logic [DW-1:0]           r_div;
  logic                    r_bclk;
  logic [PW-1:0]           r_pos;
  logic                    r_lrclk;
  logic                    r_sdata;
  logic [SAMPLE_WIDTH-1:0] r_hold;
  logic                    r_hold_valid;
  logic [SAMPLE_WIDTH-1:0] r_frame_word;
  logic                    r_primed;
  logic                    r_underrun;

  logic          w_half;
  logic          w_fall;
  logic          w_frame;
  logic          w_xfer;
  logic [PW-1:0] w_pos_next;
  logic [PW-1:0] w_k;
  logic          w_bit;

  assign w_half     = (r_div == DIV_LAST);
  assign w_fall     = w_half && r_bclk;
  assign w_pos_next = (r_pos == POS_LAST) ? '0 : r_pos + PW'(1);
  assign w_frame    = w_fall && (r_pos == POS_LAST);
  assign w_xfer     = sample_valid && !r_hold_valid;
  assign w_k        = (w_pos_next >= POS_SLOT) ? w_pos_next - POS_SLOT
                                               : w_pos_next;

  // Offset 0 and offsets past the word match nothing and stay 0.
  always_comb begin
    w_bit = 1'b0;
    for (int i = 0; i < SAMPLE_WIDTH; i++) begin
      if (w_k == PW'(SAMPLE_WIDTH - i)) w_bit = r_frame_word[i];
    end
  end

  always_ff @(posedge system_clock or negedge rst) begin
    if (!rst) begin
      r_div  <= '0;
      r_bclk <= 1'b0;
    end else if (w_half) begin
      r_div  <= '0;
      r_bclk <= ~r_bclk;
    end else begin
      r_div  <= r_div + DW'(1);
    end
  end

  always_ff @(posedge system_clock or negedge rst) begin
    if (!rst) begin
      r_pos   <= POS_LAST;
      r_lrclk <= 1'b1;
      r_sdata <= 1'b0;
    end else if (w_fall) begin
      r_pos   <= w_pos_next;
      r_lrclk <= (w_pos_next >= POS_SLOT);
      r_sdata <= w_bit;
    end
  end

  // Hold is only consumed when full and only filled when empty.
  always_ff @(posedge system_clock or negedge rst) begin
    if (!rst) begin
      r_hold       <= '0;
      r_hold_valid <= 1'b0;
      r_frame_word <= '0;
      r_primed     <= 1'b0;
      r_underrun   <= 1'b0;
    end else begin
      r_underrun <= 1'b0;
      if (w_frame) begin
        if (r_hold_valid) begin
          r_frame_word <= mute ? '0 : r_hold;
          r_hold_valid <= 1'b0;
          r_primed     <= 1'b1;
        end else begin
          if (mute) r_frame_word <= '0;
          r_underrun <= r_primed;
        end
      end
      if (w_xfer) begin
        r_hold       <= sample_in;
        r_hold_valid <= 1'b1;
      end
    end
  end

  assign sample_ready = !r_hold_valid;
  assign i2s_bclk     = r_bclk;
  assign i2s_lrclk    = r_lrclk;
  assign i2s_sdata    = r_sdata;
  assign underrun     = r_underrun;

endmodule

// File: tb/tb_i2s_tx.sv
// tb_i2s_tx: scoreboard bench for i2s_tx.
// A monitor rebuilds each frame from BCLK rises and checks it against queued words.
module tb_i2s_tx;

  localparam int SW   = 24;
  localparam int SLOT = 25;

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic signed [SW-1:0] sample_in = '0;
  logic                 sample_valid = 1'b0;
  logic                 sample_ready;
  logic                 mute = 1'b0;
  logic                 i2s_bclk;
  logic                 i2s_lrclk;
  logic                 i2s_sdata;
  logic                 underrun;

  i2s_tx dut (
    .system_clock (clk),
    .rst          (rst),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .mute         (mute),
    .i2s_bclk     (i2s_bclk),
    .i2s_lrclk    (i2s_lrclk),
    .i2s_sdata    (i2s_sdata),
    .underrun     (underrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [SW-1:0] w;
    int            ur;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string nm, input logic [31:0] got,
                       input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, got, want);
    end
  endtask

  task automatic push(input logic [SW-1:0] w, input int ur);
    exp_t e;
    e.w  = w;
    e.ur = ur;
    exp_q.push_back(e);
  endtask

  // Monitor: DAC view, sampling SDATA on each BCLK rise.
  initial begin
    logic [SLOT-1:0] lbits, rbits;
    logic [SW-1:0]   lw, rw;
    logic            prev_lr, prev_bclk, prev_ur, have_left;
    int              k, urc;
    exp_t            e;
    lbits = '0; rbits = '0;
    prev_lr = 1'b1; prev_bclk = 1'b0; prev_ur = 1'b0;
    have_left = 1'b0; k = 0; urc = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        prev_lr = 1'b1; prev_bclk = 1'b0; prev_ur = 1'b0;
        have_left = 1'b0; k = 0; urc = 0;
      end else begin
        if (underrun) begin
          urc++;
          check("underrun_width", {31'd0, prev_ur}, 32'd0);
        end
        prev_ur = underrun;
        if (i2s_bclk && !prev_bclk) begin
          if (i2s_lrclk != prev_lr) k = 0;
          else k++;
          prev_lr = i2s_lrclk;
          if (k < SLOT) begin
            if (!i2s_lrclk) begin
              lbits[k] = i2s_sdata;
              if (k == 0) have_left = 1'b1;
            end else begin
              rbits[k] = i2s_sdata;
              if (have_left && k == SLOT - 1) begin
                for (int j = 1; j <= SW; j++) begin
                  lw[SW-j] = lbits[j];
                  rw[SW-j] = rbits[j];
                end
                if (exp_q.size() == 0) begin
                  check("unexpected_frame", {8'd0, lw}, 32'd0);
                end else begin
                  e = exp_q.pop_front();
                  check("left_word", {8'd0, lw}, {8'd0, e.w});
                  check("right_word", {8'd0, rw}, {8'd0, e.w});
                  check("k0_bits", {30'd0, lbits[0], rbits[0]}, 32'd0);
                  check("underrun_count", urc, e.ur);
                end
                urc = 0;
                have_left = 1'b0;
              end
            end
          end
        end
        prev_bclk = i2s_bclk;
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_bclk"}, {31'd0, i2s_bclk}, 32'd0);
    check({tag, "_lrclk"}, {31'd0, i2s_lrclk}, 32'd1);
    check({tag, "_sdata"}, {31'd0, i2s_sdata}, 32'd0);
    check({tag, "_ready"}, {31'd0, sample_ready}, 32'd1);
    check({tag, "_underrun"}, {31'd0, underrun}, 32'd0);
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    sample_valid = 1'b0;
    mute = 1'b0;
    #100;
    check_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic wait_lr_fall(input string nm);
    logic p;
    bit   ok;
    ok = 0;
    p = i2s_lrclk;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (p && !i2s_lrclk) begin
        ok = 1;
        break;
      end
      p = i2s_lrclk;
    end
    check(nm, {31'd0, ok}, 32'd1);
  endtask

  task automatic send(input logic [SW-1:0] d);
    sample_in = d;
    sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
  endtask

  task automatic wait_drain(input string nm);
    for (int i = 0; i < 3000; i++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    check(nm, exp_q.size(), 32'd0);
  endtask

  task automatic check_start_timing(input string tag);
    int rise, fall;
    rise = -1;
    fall = -1;
    for (int e = 1; e <= 40; e++) begin
      @(posedge clk);
      #1;
      if (rise < 0 && i2s_bclk) rise = e;
      if (!i2s_lrclk) begin
        fall = e;
        check({tag, "_bclk_at_fall"}, {31'd0, i2s_bclk}, 32'd0);
        break;
      end
    end
    check({tag, "_first_rise"}, rise, 32'd10);
    check({tag, "_first_fall"}, fall, 32'd20);
  endtask

  initial begin
    int r1, r2, f1, f2, lr1, cnt;
    logic pb, pl;

    // Reset and idle timing over two silent frames.
    push(24'h000000, 0);
    push(24'h000000, 0);
    apply_reset();
    r1 = -1; r2 = -1; f1 = -1; f2 = -1; lr1 = -1;
    pb = i2s_bclk;
    pl = i2s_lrclk;
    for (int e = 1; e <= 1100; e++) begin
      @(posedge clk);
      #1;
      if (i2s_bclk && !pb) begin
        if (r1 < 0) r1 = e;
        else if (r2 < 0) r2 = e;
      end
      if (!i2s_lrclk && pl) begin
        if (f1 < 0) f1 = e;
        else if (f2 < 0) f2 = e;
      end
      if (i2s_lrclk && !pl && lr1 < 0) lr1 = e;
      pb = i2s_bclk;
      pl = i2s_lrclk;
    end
    check("idle_first_rise", r1, 32'd10);
    check("idle_bclk_period", r2 - r1, 32'd20);
    check("idle_first_fall", f1, 32'd20);
    check("idle_lr_low_len", lr1 - f1, 32'd500);
    check("idle_lr_period", f2 - f1, 32'd1000);
    wait_drain("idle_drain");

    // Single sample before the first frame start.
    apply_reset();
    push(24'hA5A5A5, 0);
    push(24'hA5A5A5, 1);
    push(24'h000001, 0);
    send(24'hA5A5A5);
    check("single_ready_low", {31'd0, sample_ready}, 32'd0);
    wait_lr_fall("single_f0");
    check("single_ready_high", {31'd0, sample_ready}, 32'd1);

    // Underrun replay, then an LSB-only word.
    wait_lr_fall("underrun_f1");
    send(24'h000001);
    wait_lr_fall("underrun_f2");

    // Backpressure: valid held high across a full hold.
    push(24'h123456, 0);
    push(24'h654321, 0);
    sample_in = 24'h123456;
    sample_valid = 1'b1;
    @(negedge clk);
    sample_in = 24'h654321;
    check("bp_ready_low", {31'd0, sample_ready}, 32'd0);
    cnt = -1;
    for (int i = 0; i < 1200; i++) begin
      @(negedge clk);
      if (sample_ready) begin
        cnt = i;
        break;
      end
    end
    check("bp_low_cycles", cnt, 32'd998);
    check("bp_ready_at_frame", {31'd0, i2s_lrclk}, 32'd0);
    @(negedge clk);
    sample_valid = 1'b0;
    check("bp_second_held", {31'd0, sample_ready}, 32'd0);

    // Mute consumes the pending word, then unmuted MSB-only word.
    push(24'h000000, 0);
    push(24'h800000, 0);
    wait_lr_fall("mute_f4");
    mute = 1'b1;
    send(24'h7FFFFF);
    check("mute_hold_full", {31'd0, sample_ready}, 32'd0);
    wait_lr_fall("mute_f5");
    check("mute_consumed", {31'd0, sample_ready}, 32'd1);
    mute = 1'b0;
    send(24'h800000);
    wait_lr_fall("mute_f6");

    // Reset mid-frame with the hold full.
    wait_lr_fall("midrst_f7");
    check("midrst_prior_drained", exp_q.size(), 32'd0);
    send(24'hABCDEF);
    repeat (604) @(negedge clk);
    check("midrst_right_slot", {31'd0, i2s_lrclk}, 32'd1);
    check("midrst_hold_full", {31'd0, sample_ready}, 32'd0);
    rst = 1'b0;
    #1;
    check_reset_outputs("midrst");
    push(24'h000000, 0);
    push(24'h000000, 0);
    #100;
    @(negedge clk);
    rst = 1'b1;
    check_start_timing("midrst");
    wait_drain("midrst_drain");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/i2s_tx.md
Name: i2s_tx

Overview:
- Audio output serializer at the end of the effects chain, after the wah stage.
- Accepts 24-bit mono samples (the `filter_out` stream) through a valid/ready handshake.
- Generates I2S bit clock, word clock and serial data toward the DAC, running entirely from the 96 MHz system clock.
- One sample is sent per frame and duplicated on the left and right channels.

Parameters:
- SAMPLE_WIDTH, 24: sample word width in bits.
- SLOT_BITS, 25: BCLK periods per channel slot; must be at least SAMPLE_WIDTH+1.
- BCLK_HALF_DIV, 10: system clocks per BCLK half-period. Defaults give a 4.8 MHz BCLK and a 96 kHz frame (1000 clocks per frame).

Ports:
- system_clock  in  1  system clock, 96 MHz.
- rst  in  1  asynchronous, active-low reset.
- sample_in  in  SAMPLE_WIDTH  signed sample to transmit.
- sample_valid  in  1  sample_in is valid this cycle.
- sample_ready  out  1  block can accept a sample this cycle.
- mute  in  1  when high at frame start, the frame transmits zeros.
- i2s_bclk  out  1  bit clock.
- i2s_lrclk  out  1  word clock; 0 = left, 1 = right.
- i2s_sdata  out  1  serial data, MSB first.
- underrun  out  1  one-cycle pulse: frame started with no new sample.

Behaviour:
- **Reset values (rst=0):**
  - div counter 0, i2s_bclk 0, bit position pos = 2*SLOT_BITS-1, i2s_lrclk 1, i2s_sdata 0.
  - hold register 0, hold_valid 0, frame_word 0, primed 0, underrun 0.
- **Divider:**
  - Counter increments every clock.
  - At count BCLK_HALF_DIV-1 it returns to 0 and i2s_bclk toggles.
  - A "fall tick" is the clock edge where i2s_bclk goes 1→0.
  - The first rise is 10 edges after reset release; the first fall is at 20.
- **On each fall tick (all registered on that edge):**
  - pos advances, wrapping 2*SLOT_BITS-1 → 0.
  - i2s_lrclk = (new pos >= SLOT_BITS).
  - Slot offset k = new pos mod SLOT_BITS.
  - k=0 → sdata 0 (I2S one-bit delay).
  - 1 <= k <= SAMPLE_WIDTH → sdata = frame_word[SAMPLE_WIDTH-k].
  - k > SAMPLE_WIDTH → sdata 0.
  - The DAC samples on the BCLK rising edge.
- **Frame start (fall tick where pos wraps to 0):** frame_word is chosen before bit output, so the left slot uses the new word.
  - If hold_valid: frame_word = mute ? 0 : hold; hold_valid cleared; primed set.
  - Else: frame_word = mute ? 0 : unchanged (last sample replayed); underrun pulses high for exactly that cycle if primed=1.
  - Before the first accepted sample, no underrun is reported.
- **Handshake:**
  - sample_ready = !hold_valid (combinational from the register).
  - Transfer occurs when sample_valid && sample_ready at a clock edge; sample_in is captured into hold and hold_valid is set.
  - A transfer and a frame-start consume cannot coincide, because ready is low while hold is full.
  - Once hold empties at frame start, ready is high on the next cycle.
  - The upstream source must hold its sample and valid stable while ready is low.
- **Sequencing:**
  - The right slot transmits the same frame_word as the left.
  - Frame latency: a sample accepted before frame start N appears on i2s_sdata starting one BCLK after that frame's LRCLK falling edge.
- **Reset mid-frame:** all state returns immediately to reset values (asynchronous). Any pending held sample is discarded; no partial bits are resumed.

Test Plan:
1. **Reset/idle:** hold rst low 100 ns, then release.
   - bclk 0, lrclk 1, sdata 0, sample_ready 1.
   - First bclk fall at edge 20 after release, lrclk → 0.
   - BCLK period 20 clocks; LRCLK period 1000 clocks with 50% duty.
   - No underrun pulses with no input.
2. **Single sample:** transfer 24'hA5A5A5 before the first frame start.
   - Left slot bits k=1..24 read 1010_0101 repeated MSB first, with k=0 and k>24 at 0.
   - Right slot is identical.
   - sample_ready goes low on transfer and high the cycle after frame start.
3. **Underrun:** after scenario 2, supply nothing.
   - Next frame start pulses underrun for 1 cycle and replays 24'hA5A5A5.
   - Supplying 24'h000001 then produces only its LSB bit set, at k=24.
4. **Backpressure:** hold sample_valid high with 24'h123456 then 24'h654321.
   - Ready stays low until frame start.
   - 24'h654321 is accepted only after, and is transmitted in the following frame; no sample is lost or duplicated.
5. **Mute:** assert mute with 24'h7FFFFF pending.
   - Frame transmits all zeros, hold is consumed, no underrun.
   - Deasserting mute in the next frame with 24'h800000 sends MSB 1 only.
6. **Reset mid-frame:** assert rst at pos 30 with hold full.
   - Outputs return to reset values immediately.
   - After release, timing restarts per scenario 1 and the old sample is never transmitted.
